lcg_shift_reg: RTL and testbench

Parametrised multi-mode shift register for the modified dual-CLCG datapath: holds an N-bit word, loads it directly or through a left/right/rotate barrel shift by a run-time amount, and also offers an area-saving serial mode that shifts one bit per clock under a small FSM with busy/done handshake. It is the next generation of the LCG shift/load register. It sits between the LCG state register and the adder that forms x·(2^r+1)+b. Unlike its predecessor it holds its contents when not started.

---
 rtl/lcg_pkg.sv | 18 +
 rtl/lcg_barrel_shift.sv | 36 +++
 rtl/lcg_shift_reg.sv | 86 ++++++++
 tb/tb_lcg_shift_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lcg_pkg.sv
// Shared encodings for the LCG shift/load register: operation modes and
// the serial-shift FSM states.
package lcg_pkg;

   typedef enum logic [2:0] {
      MODE_LOAD = 3'd0,
      MODE_SHL  = 3'd1,
      MODE_SHR  = 3'd2,
      MODE_ROL  = 3'd3,
      MODE_SSHL = 3'd4
   } mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SERIAL = 1'b1
   } state_e;

endpackage

// File: rtl/lcg_barrel_shift.sv
// Combinational barrel shifter for the single-cycle modes: SHL, SHR and ROL.
// LOAD, SSHL and the reserved codes pass the word through unchanged.
module lcg_barrel_shift
   import lcg_pkg::*;
#(
   parameter int N  = 32,
   parameter int RW = $clog2(N)
) (
   input  logic [N-1:0]  data_i,
   input  logic [RW-1:0] amount_i,
   input  logic [2:0]    mode_i,
   output logic [N-1:0]  shifted_o
);

   logic [31:0]    rot_amt;
   logic [2*N-1:0] rot_dbl;

   // Rotation wraps modulo N; shifting a doubled word keeps the wrapped
   // bits in the upper half without a variable right shift.
   always_comb begin
      rot_amt = 32'(amount_i) % 32'(N);
      rot_dbl = {data_i, data_i} << rot_amt;
   end

   // Shift amounts of N or more fall off the word and leave zero.
   always_comb begin
      shifted_o = data_i;
      case (mode_i)
         MODE_SHL: shifted_o = data_i << amount_i;
         MODE_SHR: shifted_o = data_i >> amount_i;
         MODE_ROL: shifted_o = rot_dbl[2*N-1:N];
         default:  shifted_o = data_i;
      endcase
   end

endmodule

// File: rtl/lcg_shift_reg.sv
// Multi-mode N-bit shift/load register feeding the x*(2^r+1)+b adder:
// single-cycle load/shift/rotate, plus a one-bit-per-clock serial shift left.
module lcg_shift_reg
   import lcg_pkg::*;
#(
   parameter int N  = 32,
   parameter int RW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [2:0]    mode,
   input  logic [N-1:0]  p_in,
   input  logic [RW-1:0] r,
   output logic [N-1:0]  p_out,
   output logic          busy,
   output logic          done,
   output state_e        dbg_state
);

   // Handshake: start is a one-cycle request honoured only in IDLE (busy=0);
   // done pulses for one cycle once p_out holds the final result, and a new
   // start may be presented in that same cycle.

   state_e        state_q;
   logic [N-1:0]  p_q;
   logic [RW-1:0] count_q;
   logic          busy_q;
   logic          done_q;
   logic [N-1:0]  shift_d;

   lcg_barrel_shift #(.N(N), .RW(RW)) u_shift (
      .data_i    (p_in),
      .amount_i  (r),
      .mode_i    (mode),
      .shifted_o (shift_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         p_q     <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (mode == MODE_SSHL) begin
                     p_q     <= p_in;
                     count_q <= r;
                     if (r == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        state_q <= ST_SERIAL;
                        busy_q  <= 1'b1;
                     end
                  end else begin
                     p_q    <= shift_d;
                     done_q <= 1'b1;
                  end
               end
            end
            ST_SERIAL: begin
               // count_q holds the shifts still to do, including this one.
               p_q     <= p_q << 1;
               count_q <= count_q - RW'(1);
               if (count_q == RW'(1)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign p_out     = p_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_lcg_shift_reg.sv
// Self-checking bench for lcg_shift_reg (N=8): directed cases followed by
// randomized traffic against a per-cycle expectation queue.
module tb_lcg_shift_reg;
   import lcg_pkg::*;

   localparam int N  = 8;
   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    mode;
   logic [N-1:0]  p_in;
   logic [RW-1:0] r;
   logic [N-1:0]  p_out;
   logic          busy;
   logic          done;
   state_e        dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Each entry is {p_out, busy, done} expected after one future clock edge.
   logic [N+1:0] exp_q[$];
   logic [N-1:0] cur_p;
   logic         cur_busy;
   logic         cur_done;

   lcg_shift_reg #(.N(N), .RW(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .p_in      (p_in),
      .r         (r),
      .p_out     (p_out),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Result of a single-cycle operation from plain integer arithmetic.
   function automatic logic [N-1:0] ref_op(input logic [2:0] m, input logic [N-1:0] p,
                                            input logic [RW-1:0] amt);
      int pv, a, k, res;
      pv = int'(p);
      a  = int'(amt);
      k  = a % N;
      case (m)
         3'd1:    res = (pv * (2 ** a)) % (2 ** N);
         3'd2:    res = pv / (2 ** a);
         3'd3:    res = (pv * (2 ** k) + pv / (2 ** (N - k))) % (2 ** N);
         default: res = pv;
      endcase
      return res[N-1:0];
   endfunction

   task automatic compare_outputs(input string tag);
      check({tag, "_p"},     32'(p_out), 32'(cur_p));
      check({tag, "_busy"},  32'(busy),  32'(cur_busy));
      check({tag, "_done"},  32'(done),  32'(cur_done));
      check({tag, "_state"}, 32'(dbg_state), cur_busy ? 32'(ST_SERIAL) : 32'(ST_IDLE));
   endtask

   // Advance the model across one rising edge, then compare.
   task automatic step(input string tag);
      logic [N+1:0] nxt;
      int           k;
      if (exp_q.size() > 0) begin
         nxt = exp_q.pop_front();
      end else if (start && !cur_busy) begin
         if (mode == 3'd4) begin
            k = int'(r);
            for (int j = 0; j <= k; j++) begin
               int v;
               v = (int'(p_in) * (2 ** j)) % (2 ** N);
               exp_q.push_back({v[N-1:0], (j < k), (j == k)});
            end
            nxt = exp_q.pop_front();
         end else begin
            nxt = {ref_op(mode, p_in, r), 1'b0, 1'b1};
         end
      end else begin
         nxt = {cur_p, 1'b0, 1'b0};
      end
      @(posedge clk);
      #1;
      {cur_p, cur_busy, cur_done} = nxt;
      compare_outputs(tag);
   endtask

   task automatic op(input string tag, input logic [2:0] m, input logic [N-1:0] p,
                     input logic [RW-1:0] amt);
      start = 1'b1;
      mode  = m;
      p_in  = p;
      r     = amt;
      step(tag);
      start = 1'b0;
   endtask

   task automatic idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) step(tag);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic apply_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      cur_p    = '0;
      cur_busy = 1'b0;
      cur_done = 1'b0;
      compare_outputs(tag);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      mode  = '0;
      p_in  = '0;
      r     = '0;
      apply_reset("reset");
      idle("reset_hold", 5);

      op("shl", 3'd1, 8'hB5, 3'd3);
      check("shl_lit", 32'(p_out), 32'h A8);
      idle("shl_hold", 2);
      op("shr", 3'd2, 8'hB5, 3'd3);
      check("shr_lit", 32'(p_out), 32'h16);
      idle("shr_hold", 2);
      op("rol", 3'd3, 8'hB5, 3'd3);
      check("rol_lit", 32'(p_out), 32'hAD);
      idle("rol_hold", 2);
      op("load", 3'd0, 8'hB5, 3'd3);
      check("load_lit", 32'(p_out), 32'hB5);
      op("rsvd", 3'd6, 8'hB5, 3'd3);
      check("rsvd_lit", 32'(p_out), 32'hB5);
      idle("rsvd_hold", 2);

      op("sshl5", 3'd4, 8'h01, 3'd5);
      for (int i = 0; i < 4; i++) op("sshl5_ignored", 3'd0, 8'hFF, 3'd0);
      step("sshl5_last");
      check("sshl5_final", 32'(p_out), 32'h20);
      idle("sshl5_hold", 2);

      op("sshl0", 3'd4, 8'h3C, 3'd0);
      check("sshl0_lit", 32'(p_out), 32'h3C);
      idle("sshl0_hold", 2);

      op("sshl7", 3'd4, 8'hFF, 3'd7);
      idle("sshl7_run", 7);
      check("sshl7_final", 32'(p_out), 32'h80);
      idle("sshl7_hold", 1);

      op("sshl6", 3'd4, 8'hAA, 3'd6);
      idle("sshl6_run", 3);
      apply_reset("reset_mid");
      idle("reset_mid_quiet", 6);
      op("shl_after_reset", 3'd1, 8'h41, 3'd1);
      check("shl_after_reset_lit", 32'(p_out), 32'h82);

      op("b2b_sshl", 3'd4, 8'h01, 3'd2);
      idle("b2b_run", 2);
      op("b2b_rol", 3'd3, 8'h81, 3'd1);
      check("b2b_rol_lit", 32'(p_out), 32'h03);
      idle("b2b_hold", 1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            apply_reset("rand_reset");
         end
         start = ($urandom_range(0, 2) == 0);
         mode  = 3'($urandom_range(0, 7));
         p_in  = 8'($urandom);
         r     = 3'($urandom_range(0, 7));
         step("rand");
         start = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
